// File: rtl/e_mdu_if.sv
// e_mdu_if -- E-stage request/result bundle for the multiply/divide unit.
//
// Signals:
//   start  : qualifies op for the single E-stage cycle of the instruction
//   op     : 4-bit operation code (see e_mdu)
//   A, B   : forwarded rs / rt operands
//   busy   : a multi-cycle operation is in progress
//   hi, lo : current HI / LO register contents
//
// Modports:
//   master : the pipeline side (drives the request, observes busy/hi/lo)
//   slave  : the multiply/divide unit
interface e_mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, A, B, input  busy, hi, lo);
  modport slave  (input  start, op, A, B, output busy, hi, lo);
endinterface

// File: rtl/e_mdu.sv
// e_mdu -- execute-stage multiply/divide unit with HI/LO registers.
//
// The result of a MULT/MULTU/DIV/DIVU is computed when the operation is
// accepted and held in a pending register; HI/LO are only written once the
// programmed latency has elapsed, while busy stalls later HI/LO users.
// MTHI/MTLO write HI/LO at the sampling edge. HI/LO are read directly from
// the registers (no bypass of an in-flight result).
//
// Parameters:
//   MULT_CYCLES : edges from an accepted multiply to the HI/LO update (1..15)
//   DIV_CYCLES  : edges from an accepted divide to the HI/LO update (1..15)
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   mdu   : e_mdu_if.slave (start, op, A, B in; busy, hi, lo out)
//
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU
// (op codes 7..10), which accumulate into {HI,LO} with MULT_CYCLES latency.
// Without it those codes behave as NONE.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave mdu
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_e      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] p_hi, p_hi_n;
  logic [31:0] p_lo, p_lo_n;
  logic        p_we, p_we_n;
  logic [31:0] hi_r, hi_n;
  logic [31:0] lo_r, lo_n;

  // ---------------------------------------------------------------------
  // Arithmetic, evaluated on the live operands in the accepting cycle
  // ---------------------------------------------------------------------
  logic signed [31:0] a_s, b_s;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;

  assign a_s    = $signed(mdu.A);
  assign b_s    = $signed(mdu.B);
  assign prod_s = 64'(a_s) * 64'(b_s);
  assign prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};

  // The divisor is replaced by 1 for a zero divisor (result is discarded)
  // and for 0x80000000 / -1: dividing by 1 there yields exactly the wrapped
  // quotient 0x80000000 with remainder 0, and avoids an overflowing divide.
  logic               div_ovf;
  logic signed [31:0] b_div_s;
  logic        [31:0] b_div_u;
  logic signed [31:0] quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;

  assign div_ovf = (mdu.A == 32'h8000_0000) && (mdu.B == 32'hFFFF_FFFF);
  assign b_div_s = (mdu.B == 32'd0 || div_ovf) ? 32'sd1 : b_s;
  assign b_div_u = (mdu.B == 32'd0) ? 32'd1 : mdu.B;
  assign quot_s  = a_s / b_div_s;   // truncates toward zero
  assign rem_s   = a_s % b_div_s;   // takes the dividend's sign
  assign quot_u  = mdu.A / b_div_u;
  assign rem_u   = mdu.A % b_div_u;

`ifdef MDU_MADD_EN
  // Accumulate operations use the {HI,LO} value present at the start edge.
  logic [63:0] acc;
  assign acc = {hi_r, lo_r};
`endif

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case statements can leave one unassigned and infer a latch.
    state_n = state;
    cnt_n   = cnt;
    p_hi_n  = p_hi;
    p_lo_n  = p_lo;
    p_we_n  = p_we;
    hi_n    = hi_r;
    lo_n    = lo_r;

    unique case (state)
      S_IDLE: begin
        if (mdu.start) begin
          case (mdu.op)
            OP_MULT: begin
              {p_hi_n, p_lo_n} = prod_s;
              p_we_n  = 1'b1;
              cnt_n   = MULT_LOAD;
              state_n = S_RUN;
            end
            OP_MULTU: begin
              {p_hi_n, p_lo_n} = prod_u;
              p_we_n  = 1'b1;
              cnt_n   = MULT_LOAD;
              state_n = S_RUN;
            end
            OP_DIV: begin
              p_hi_n  = rem_s;
              p_lo_n  = quot_s;
              p_we_n  = (mdu.B != 32'd0);
              cnt_n   = DIV_LOAD;
              state_n = S_RUN;
            end
            OP_DIVU: begin
              p_hi_n  = rem_u;
              p_lo_n  = quot_u;
              p_we_n  = (mdu.B != 32'd0);
              cnt_n   = DIV_LOAD;
              state_n = S_RUN;
            end
            OP_MTHI: hi_n = mdu.A;
            OP_MTLO: lo_n = mdu.A;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              {p_hi_n, p_lo_n} = acc + prod_s;
              p_we_n  = 1'b1;
              cnt_n   = MULT_LOAD;
              state_n = S_RUN;
            end
            OP_MADDU: begin
              {p_hi_n, p_lo_n} = acc + prod_u;
              p_we_n  = 1'b1;
              cnt_n   = MULT_LOAD;
              state_n = S_RUN;
            end
            OP_MSUB: begin
              {p_hi_n, p_lo_n} = acc - prod_s;
              p_we_n  = 1'b1;
              cnt_n   = MULT_LOAD;
              state_n = S_RUN;
            end
            OP_MSUBU: begin
              {p_hi_n, p_lo_n} = acc - prod_u;
              p_we_n  = 1'b1;
              cnt_n   = MULT_LOAD;
              state_n = S_RUN;
            end
`endif
            default: ;  // NONE and undefined codes
          endcase
        end
      end

      S_RUN: begin
        // start is ignored here; the hazard unit never issues during busy.
        if (cnt == 4'd0) begin
          if (p_we) begin
            hi_n = p_hi;
            lo_n = p_lo;
          end
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
      p_we  <= 1'b0;
      hi_r  <= 32'd0;
      lo_r  <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      p_hi  <= p_hi_n;
      p_lo  <= p_lo_n;
      p_we  <= p_we_n;
      hi_r  <= hi_n;
      lo_r  <= lo_n;
    end
  end

  assign mdu.busy = (state == S_RUN);
  assign mdu.hi   = hi_r;
  assign mdu.lo   = lo_r;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu -- scoreboard testbench for e_mdu.
//
// The driver issues operations, evaluates each one with plain 64-bit integer
// arithmetic, and queues the HI/LO values expected at specific cycles together
// with the expected busy window. A monitor on the falling clock edge checks
// busy every cycle and pops/compares scoreboard entries as they come due.
module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;
  e_mdu_if mif();

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .reset(reset),
    .mdu  (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  bit          mon_en      = 1'b0;
  int          bstart      = 0;
  int          bend        = 0;
  logic [31:0] m_hi        = '0;
  logic [31:0] m_lo        = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: busy every cycle, HI/LO whenever a scoreboard entry comes due.
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", {63'd0, mif.busy}, {63'd0, (cyc >= bstart && cyc < bend)});
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, " hi"}, {32'd0, mif.hi}, {32'd0, e.hi});
        check({e.tag, " lo"}, {32'd0, mif.lo}, {32'd0, e.lo});
      end
    end
  end

  function automatic string op_name(input logic [3:0] o);
    case (o)
      4'd1: return "MULT";
      4'd2: return "MULTU";
      4'd3: return "DIV";
      4'd4: return "DIVU";
      4'd5: return "MTHI";
      4'd6: return "MTLO";
      4'd7: return "MADD";
      4'd8: return "MADDU";
      4'd9: return "MSUB";
      4'd10: return "MSUBU";
      default: return "NONE";
    endcase
  endfunction

  // Issue one operation, model it, queue expectations, and wait until the
  // pipeline would be allowed to issue the next HI/LO operation.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int              t0, n;
    longint          sa, sb_, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     res;
    logic [63:0]     acc;
    bit              we;
    string           nm;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    acc = {m_hi, m_lo};
    n   = 0;
    we  = 1'b0;
    res = acc;
    nm  = op_name(o);
    case (o)
      4'd1: begin n = MULT_N; we = 1'b1; res = 64'(sa * sb_); end
      4'd2: begin n = MULT_N; we = 1'b1; res = 64'(ua * ub); end
      4'd3: begin
        n = DIV_N;
        if (b != 0) begin
          sq = sa / sb_;
          sr = sa % sb_;
          we = 1'b1;
          res = {sr[31:0], sq[31:0]};
        end
      end
      4'd4: begin
        n = DIV_N;
        if (b != 0) begin
          we = 1'b1;
          res = {32'(ua % ub), 32'(ua / ub)};
        end
      end
      4'd5: res = {a, m_lo};
      4'd6: res = {m_hi, a};
`ifdef MDU_MADD_EN
      4'd7:  begin n = MULT_N; we = 1'b1; res = acc + 64'(sa * sb_); end
      4'd8:  begin n = MULT_N; we = 1'b1; res = acc + 64'(ua * ub); end
      4'd9:  begin n = MULT_N; we = 1'b1; res = acc - 64'(sa * sb_); end
      4'd10: begin n = MULT_N; we = 1'b1; res = acc - 64'(ua * ub); end
`endif
      default: ;
    endcase

    @(negedge clk); #1;
    t0 = cyc + 1;               // edge that samples start
    mif.start = 1'b1;
    mif.op    = o;
    mif.A     = a;
    mif.B     = b;
    if (n > 0) begin
      bstart = t0;
      bend   = t0 + n;
      if (n > 1) sb.push_back('{t0 + n - 1, m_hi, m_lo, {nm, " pre"}});
      if (we) begin
        m_hi = res[63:32];
        m_lo = res[31:0];
      end
      sb.push_back('{t0 + n, m_hi, m_lo, {nm, " done"}});
    end else begin
      m_hi = res[63:32];
      m_lo = res[31:0];
      sb.push_back('{t0, m_hi, m_lo, nm});
    end
    @(negedge clk); #1;
    mif.start = 1'b0;
    mif.op    = $urandom_range(0, 15);  // op/A/B are don't-care without start
    mif.A     = $urandom;
    mif.B     = $urandom;
    while (cyc < t0 + n - 1) @(negedge clk);
  endtask

  initial begin
    int t0;
    reset     = 1'b1;
    mif.start = 1'b0;
    mif.op    = 4'd0;
    mif.A     = '0;
    mif.B     = '0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    sb.push_back('{cyc + 1, 32'd0, 32'd0, "reset"});
    mon_en = 1'b1;

    // Directed cases
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);          // -2 * 3
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);          // -7 / 2
    issue(4'd4, 32'd7, 32'd0);                  // divide by zero
    issue(4'd5, 32'h1234_5678, 32'd0);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);  // overflow case
    issue(4'd3, 32'd7, 32'hFFFF_FFFE);          // 7 / -2
    issue(4'd6, 32'hCAFE_F00D, 32'd0);

    // Reset during the third cycle of a DIV
    @(negedge clk); #1;
    t0 = cyc + 1;
    mif.start = 1'b1;
    mif.op    = 4'd3;
    mif.A     = 32'd100;
    mif.B     = 32'd7;
    bstart    = t0;
    bend      = t0 + DIV_N;
    @(negedge clk); #1;
    mif.start = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;                          // cyc = t0+2
    reset = 1'b1;                                // reset edge t0+3
    bend  = t0 + 3;
    m_hi  = '0;
    m_lo  = '0;
    sb.push_back('{t0 + 3, 32'd0, 32'd0, "reset mid-DIV"});
    sb.push_back('{t0 + DIV_N, 32'd0, 32'd0, "no write after reset"});
    @(negedge clk); #1;
    reset = 1'b0;
    while (cyc < t0 + DIV_N) @(negedge clk);

    // Accumulate carry case (enabled or NONE depending on the build)
    issue(4'd5, 32'd0, 32'd0);
    issue(4'd6, 32'hFFFF_FFFF, 32'd0);
    issue(4'd8, 32'd1, 32'd1);
    issue(4'd9, 32'h0000_0003, 32'hFFFF_FFFF);   // MSUB with -1

    // Randomized operations
    for (int i = 0; i < 120; i++) begin
      logic [3:0]  o;
      logic [31:0] a, b;
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = 32'($urandom_range(0, 20)) - 32'd10;
        default: ;
      endcase
      issue(o, a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
